// File: rtl/dfx_reconfig_ctrl_if.sv
// Host/core/config-port signal bundle for the RP reconfiguration sequencer.
// master = sequencer side, slave = environment (host, core top, config port).
interface dfx_reconfig_ctrl_if;
    logic        reconf_req_i;
    logic        reconf_busy_o;
    logic        reconf_done_o;
    logic        reconf_err_o;
    logic        shutdown_req_o;
    logic        shutdown_ack_i;
    logic        dfx_decouple_o;
    logic        rp_reset_o;
    logic        icap_start_o;
    logic        icap_done_i;
    logic        icap_err_i;
    logic [2:0]  state_o;
    logic [15:0] reconf_count_o;

    modport master (
        input  reconf_req_i, shutdown_ack_i, icap_done_i, icap_err_i,
        output reconf_busy_o, reconf_done_o, reconf_err_o, shutdown_req_o,
               dfx_decouple_o, rp_reset_o, icap_start_o, state_o, reconf_count_o
    );

    modport slave (
        output reconf_req_i, shutdown_ack_i, icap_done_i, icap_err_i,
        input  reconf_busy_o, reconf_done_o, reconf_err_o, shutdown_req_o,
               dfx_decouple_o, rp_reset_o, icap_start_o, state_o, reconf_count_o
    );
endinterface

// File: rtl/dfx_reconfig_ctrl.sv
// RP reconfiguration sequencer: quiesce, decouple, load, reset hold, release.
// All outputs registered, reacting one cycle after sampled inputs; no backpressure, requests while busy are dropped.
module dfx_reconfig_ctrl #(
    parameter int TimeoutCycles   = 1024,
    parameter int ResetHoldCycles = 16
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    dfx_reconfig_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SHUTDOWN = 3'd1,
        DECOUPLE = 3'd2,
        LOAD     = 3'd3,
        RESET    = 3'd4,
        RELEASE  = 3'd5,
        ERROR    = 3'd6
    } state_e;

    typedef struct packed {
        logic busy;
        logic err;
        logic sreq;
        logic dec;
        logic rst;
    } ctl_t;

    localparam int MaxCycles = (TimeoutCycles > ResetHoldCycles) ? TimeoutCycles : ResetHoldCycles;
    localparam int TimerW    = $clog2(MaxCycles + 1);

    state_e              r_state;
    ctl_t                r_ctl;
    logic [TimerW-1:0]   r_timer;
    logic                r_err_load;
    logic                r_start;
    logic                r_done;
    logic [15:0]         r_count;

    // Control levels that hold while sitting in state s; a load failure keeps the RP isolated.
    function automatic ctl_t ctl_for(input state_e s, input logic load_err);
        ctl_t c;
        c = '0;
        case (s)
            SHUTDOWN: begin c.busy = 1'b1; c.sreq = 1'b1; end
            DECOUPLE: begin c.busy = 1'b1; c.sreq = 1'b1; c.dec = 1'b1; c.rst = 1'b1; end
            LOAD:     begin c.busy = 1'b1; c.dec = 1'b1; c.rst = 1'b1; end
            RESET:    begin c.busy = 1'b1; c.dec = 1'b1; c.rst = 1'b1; end
            RELEASE:  begin c.busy = 1'b1; c.dec = 1'b1; end
            ERROR:    begin c.err = 1'b1; c.dec = load_err; c.rst = load_err; end
            default:  c = '0;
        endcase
        return c;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_ctl      <= '0;
            r_timer    <= '0;
            r_err_load <= 1'b0;
            r_start    <= 1'b0;
            r_done     <= 1'b0;
            r_count    <= '0;
        end else begin
            r_start <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.reconf_req_i) begin
                        r_state <= SHUTDOWN;
                        r_timer <= '0;
                        r_ctl   <= ctl_for(SHUTDOWN, 1'b0);
                    end
                end
                SHUTDOWN: begin
                    if (bus.shutdown_ack_i) begin
                        r_state <= DECOUPLE;
                        r_ctl   <= ctl_for(DECOUPLE, 1'b0);
                    end else if (r_timer == TimerW'(TimeoutCycles - 1)) begin
                        r_state    <= ERROR;
                        r_err_load <= 1'b0;
                        r_ctl      <= ctl_for(ERROR, 1'b0);
                    end else begin
                        r_timer <= r_timer + TimerW'(1);
                    end
                end
                DECOUPLE: begin
                    r_state <= LOAD;
                    r_start <= 1'b1;
                    r_ctl   <= ctl_for(LOAD, 1'b0);
                end
                LOAD: begin
                    if (bus.icap_err_i) begin
                        r_state    <= ERROR;
                        r_err_load <= 1'b1;
                        r_ctl      <= ctl_for(ERROR, 1'b1);
                    end else if (bus.icap_done_i) begin
                        r_state <= RESET;
                        r_timer <= '0;
                        r_ctl   <= ctl_for(RESET, 1'b0);
                    end
                end
                RESET: begin
                    if (r_timer == TimerW'(ResetHoldCycles - 1)) begin
                        r_state <= RELEASE;
                        r_ctl   <= ctl_for(RELEASE, 1'b0);
                    end else begin
                        r_timer <= r_timer + TimerW'(1);
                    end
                end
                RELEASE: begin
                    r_state <= IDLE;
                    r_ctl   <= ctl_for(IDLE, 1'b0);
                    r_done  <= 1'b1;
                    if (r_count != 16'hFFFF) begin
                        r_count <= r_count + 16'd1;
                    end
                end
                ERROR: begin
                    // A failed load leaves the core quiesced, so the retry skips the shutdown handshake.
                    if (bus.reconf_req_i) begin
                        if (r_err_load) begin
                            r_state <= DECOUPLE;
                            r_ctl   <= ctl_for(DECOUPLE, 1'b0);
                        end else begin
                            r_state <= SHUTDOWN;
                            r_timer <= '0;
                            r_ctl   <= ctl_for(SHUTDOWN, 1'b0);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ctl   <= '0;
                end
            endcase
        end
    end

    assign bus.reconf_busy_o  = r_ctl.busy;
    assign bus.reconf_err_o   = r_ctl.err;
    assign bus.shutdown_req_o = r_ctl.sreq;
    assign bus.dfx_decouple_o = r_ctl.dec;
    assign bus.rp_reset_o     = r_ctl.rst;
    assign bus.icap_start_o   = r_start;
    assign bus.reconf_done_o  = r_done;
    assign bus.state_o        = r_state;
    assign bus.reconf_count_o = r_count;
endmodule

// File: tb/tb_dfx_reconfig_ctrl.sv
// Directed bench for dfx_reconfig_ctrl: expected completions/errors are queued when a
// request is issued and matched against the done pulse or error entry the DUT produces.
module tb_dfx_reconfig_ctrl;
    localparam int TO = 8;
    localparam int RH = 16;

    localparam logic [2:0] S_IDLE = 3'd0, S_SHUT = 3'd1, S_DEC = 3'd2, S_LOAD = 3'd3,
                           S_RST = 3'd4, S_ERR = 3'd6;

    typedef struct packed {
        logic        is_err;
        logic [15:0] count;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    exp_t sb[$];

    // Monitor state, written only by the monitor process.
    int n_start, n_rst_hi, cyc_cnt, rst_fall, dec_fall, n_viol;
    logic prev_rst, prev_dec;

    dfx_reconfig_ctrl_if bus();

    dfx_reconfig_ctrl #(
        .TimeoutCycles  (TO),
        .ResetHoldCycles(RH)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        n_start = 0; n_rst_hi = 0; cyc_cnt = 0; rst_fall = 0; dec_fall = 0; n_viol = 0;
        prev_rst = 1'b0; prev_dec = 1'b0;
    end

    always @(negedge clk) begin
        cyc_cnt++;
        if (bus.icap_start_o === 1'b1) n_start++;
        if (bus.rp_reset_o === 1'b1) n_rst_hi++;
        if (prev_rst && !bus.rp_reset_o) rst_fall = cyc_cnt;
        if (prev_dec && !bus.dfx_decouple_o) dec_fall = cyc_cnt;
        if (bus.rp_reset_o && !bus.dfx_decouple_o) n_viol++;
        if (bus.icap_start_o && !bus.dfx_decouple_o) n_viol++;
        prev_rst = bus.rp_reset_o;
        prev_dec = bus.dfx_decouple_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until a done pulse or error state appears, then matches it with the queue head.
    task automatic wait_evt(input string tag, input int budget, output int cyc);
        exp_t e;
        bit   got;
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < budget) begin
            step();
            cyc++;
            if (bus.reconf_done_o === 1'b1 || bus.reconf_err_o === 1'b1) got = 1'b1;
        end
        n_checks++;
        assert (got && sb.size() > 0) else begin
            n_errors++;
            $error("FAIL %s observed=no_event_or_empty_queue expected=event_within_%0d", tag, budget);
        end
        if (got && sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "/kind_err"}, 32'(bus.reconf_err_o), 32'(e.is_err));
            chk({tag, "/count"}, 32'(bus.reconf_count_o), 32'(e.count));
        end
    endtask

    initial begin
        int   cyc;
        int   s0, r0;
        exp_t e;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        bus.reconf_req_i = 1'b0;
        bus.shutdown_ack_i = 1'b0;
        bus.icap_done_i = 1'b0;
        bus.icap_err_i = 1'b0;
        #12;
        chk("rst/state", 32'(bus.state_o), 32'(S_IDLE));
        chk("rst/ctl", 32'({bus.reconf_busy_o, bus.reconf_done_o, bus.reconf_err_o, bus.shutdown_req_o,
                            bus.dfx_decouple_o, bus.rp_reset_o, bus.icap_start_o}), 32'd0);
        chk("rst/count", 32'(bus.reconf_count_o), 32'd0);
        rst_n = 1'b1;
        step();

        // Nominal: ack 3 cycles after SHUTDOWN entry, LOAD lasts 10 cycles.
        s0 = n_start; r0 = n_rst_hi;
        bus.reconf_req_i = 1'b1;
        e.is_err = 1'b0; e.count = 16'd1; sb.push_back(e);
        step();
        chk("nom/shutdown", 32'({bus.state_o, bus.shutdown_req_o, bus.reconf_busy_o}), 32'({S_SHUT, 2'b11}));
        bus.reconf_req_i = 1'b0;
        repeat (3) step();
        bus.shutdown_ack_i = 1'b1;
        step();
        chk("nom/decouple", 32'({bus.state_o, bus.dfx_decouple_o, bus.rp_reset_o, bus.shutdown_req_o}),
            32'({S_DEC, 3'b111}));
        bus.shutdown_ack_i = 1'b0;
        step();
        chk("nom/load", 32'({bus.state_o, bus.icap_start_o, bus.shutdown_req_o}), 32'({S_LOAD, 2'b10}));
        step();
        chk("nom/start_one_cycle", 32'(bus.icap_start_o), 32'd0);
        repeat (8) step();
        bus.icap_done_i = 1'b1;
        wait_evt("nom/done", 100, cyc);
        bus.icap_done_i = 1'b0;
        chk("nom/idle_dec", 32'({bus.state_o, bus.dfx_decouple_o, bus.rp_reset_o}), 32'({S_IDLE, 2'b00}));
        #5;
        chk("nom/start_count", 32'(n_start - s0), 32'd1);
        chk("nom/rp_reset_cycles", 32'(n_rst_hi - r0), 32'(1 + 10 + RH));
        chk("nom/dec_after_rst", 32'(dec_fall - rst_fall), 32'd1);
        step();
        chk("nom/done_pulse", 32'(bus.reconf_done_o), 32'd0);

        // Shutdown timeout, ack never comes.
        s0 = n_start;
        bus.reconf_req_i = 1'b1;
        e.is_err = 1'b1; e.count = 16'd1; sb.push_back(e);
        step();
        bus.reconf_req_i = 1'b0;
        wait_evt("to/err", 50, cyc);
        chk("to/latency", 32'(cyc), 32'(TO));
        chk("to/outputs", 32'({bus.state_o, bus.reconf_err_o, bus.reconf_busy_o, bus.shutdown_req_o,
                               bus.dfx_decouple_o, bus.rp_reset_o}), 32'({S_ERR, 5'b10000}));
        #5;
        chk("to/no_start", 32'(n_start - s0), 32'd0);

        // Retry after timeout goes through SHUTDOWN, then the load fails.
        bus.reconf_req_i = 1'b1;
        step();
        chk("to_retry/shutdown", 32'(bus.state_o), 32'(S_SHUT));
        bus.reconf_req_i = 1'b0;
        bus.shutdown_ack_i = 1'b1;
        step();
        bus.shutdown_ack_i = 1'b0;
        step();
        bus.icap_err_i = 1'b1;
        e.is_err = 1'b1; e.count = 16'd1; sb.push_back(e);
        wait_evt("lerr/err", 10, cyc);
        bus.icap_err_i = 1'b0;
        chk("lerr/outputs", 32'({bus.state_o, bus.dfx_decouple_o, bus.rp_reset_o, bus.shutdown_req_o}),
            32'({S_ERR, 3'b110}));
        step();
        chk("lerr/hold", 32'({bus.state_o, bus.dfx_decouple_o, bus.rp_reset_o}), 32'({S_ERR, 2'b11}));

        // Load-error retry skips quiesce.
        bus.reconf_req_i = 1'b1;
        e.is_err = 1'b0; e.count = 16'd2; sb.push_back(e);
        step();
        chk("lretry/decouple", 32'(bus.state_o), 32'(S_DEC));
        bus.reconf_req_i = 1'b0;
        step();
        chk("lretry/start", 32'({bus.state_o, bus.icap_start_o}), 32'({S_LOAD, 1'b1}));
        bus.icap_done_i = 1'b1;
        wait_evt("lretry/done", 50, cyc);
        bus.icap_done_i = 1'b0;
        chk("lretry/latency", 32'(cyc), 32'(RH + 2));

        // Ack on the last timeout cycle wins; then done+err together gives ERROR.
        bus.reconf_req_i = 1'b1;
        step();
        bus.reconf_req_i = 1'b0;
        repeat (TO - 1) step();
        chk("sim/still_shutdown", 32'(bus.state_o), 32'(S_SHUT));
        bus.shutdown_ack_i = 1'b1;
        step();
        chk("sim/ack_wins", 32'(bus.state_o), 32'(S_DEC));
        bus.shutdown_ack_i = 1'b0;
        step();
        bus.icap_done_i = 1'b1;
        bus.icap_err_i = 1'b1;
        e.is_err = 1'b1; e.count = 16'd2; sb.push_back(e);
        wait_evt("sim/err_wins", 10, cyc);
        bus.icap_done_i = 1'b0;
        bus.icap_err_i = 1'b0;
        chk("sim/err_state", 32'(bus.state_o), 32'(S_ERR));
        bus.reconf_req_i = 1'b1;
        e.is_err = 1'b0; e.count = 16'd3; sb.push_back(e);
        step();
        bus.reconf_req_i = 1'b0;
        step();
        bus.icap_done_i = 1'b1;
        wait_evt("sim/recover", 50, cyc);
        bus.icap_done_i = 1'b0;

        // Request held high: ignored while busy, back-to-back restart from IDLE.
        bus.reconf_req_i = 1'b1;
        bus.shutdown_ack_i = 1'b1;
        bus.icap_done_i = 1'b1;
        e.is_err = 1'b0; e.count = 16'd4; sb.push_back(e);
        e.is_err = 1'b0; e.count = 16'd5; sb.push_back(e);
        wait_evt("busy/first", 100, cyc);
        chk("busy/min_latency", 32'(cyc), 32'(5 + RH));
        chk("busy/idle", 32'(bus.state_o), 32'(S_IDLE));
        step();
        chk("busy/b2b_start", 32'(bus.state_o), 32'(S_SHUT));
        wait_evt("busy/second", 100, cyc);
        chk("busy/second_latency", 32'(cyc), 32'(4 + RH));
        bus.reconf_req_i = 1'b0;
        bus.shutdown_ack_i = 1'b0;
        bus.icap_done_i = 1'b0;
        step();
        chk("busy/settled", 32'(bus.state_o), 32'(S_IDLE));

        // Count saturation.
        force dut.r_count = 16'hFFFF;
        #1;
        release dut.r_count;
        step();
        chk("sat/preload", 32'(bus.reconf_count_o), 32'hFFFF);
        bus.reconf_req_i = 1'b1;
        bus.shutdown_ack_i = 1'b1;
        bus.icap_done_i = 1'b1;
        e.is_err = 1'b0; e.count = 16'hFFFF; sb.push_back(e);
        wait_evt("sat/done", 100, cyc);
        bus.reconf_req_i = 1'b0;
        bus.shutdown_ack_i = 1'b0;
        bus.icap_done_i = 1'b0;
        step();
        chk("sat/held", 32'(bus.reconf_count_o), 32'hFFFF);

        // Asynchronous reset during LOAD.
        bus.reconf_req_i = 1'b1;
        bus.shutdown_ack_i = 1'b1;
        repeat (3) step();
        chk("arst/in_load", 32'(bus.state_o), 32'(S_LOAD));
        bus.reconf_req_i = 1'b0;
        bus.shutdown_ack_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst/outputs", 32'({bus.reconf_busy_o, bus.reconf_done_o, bus.reconf_err_o, bus.shutdown_req_o,
                                 bus.dfx_decouple_o, bus.rp_reset_o, bus.icap_start_o}), 32'd0);
        chk("arst/state", 32'({bus.state_o, bus.reconf_count_o}), 32'd0);
        #4;
        rst_n = 1'b1;
        repeat (2) step();
        chk("arst/idle_after", 32'({bus.state_o, bus.reconf_busy_o}), 32'd0);

        chk("inv/no_violations", 32'(n_viol), 32'd0);
        chk("sb/drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
